// File: rtl/dot_result_requant_pkg.sv
// Shared widths, requant configuration type and output saturation helper
// for the dot-product result requantizer.
package dot_result_requant_pkg;

  localparam int IN_WIDTH    = 32;
  localparam int SCALE_WIDTH = 16;
  localparam int OUT_WIDTH   = 8;
  localparam int SHIFT_WIDTH = 5;
  localparam int PROD_WIDTH  = IN_WIDTH + SCALE_WIDTH + 1;
  localparam int SUM_WIDTH   = PROD_WIDTH + 1;

  localparam logic signed [SUM_WIDTH-1:0] OUT_MAX = SUM_WIDTH'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [SUM_WIDTH-1:0] OUT_MIN = SUM_WIDTH'(-(2 ** (OUT_WIDTH - 1)));

  typedef struct packed {
    logic [SCALE_WIDTH-1:0] scale;
    logic [SHIFT_WIDTH-1:0] shift;
    logic [OUT_WIDTH-1:0]   zero_point;
  } requant_cfg_t;

  function automatic logic signed [OUT_WIDTH-1:0] saturate(input logic signed [SUM_WIDTH-1:0] v);
    logic signed [OUT_WIDTH-1:0] res;
    if (v > OUT_MAX)      res = OUT_WIDTH'(OUT_MAX);
    else if (v < OUT_MIN) res = OUT_WIDTH'(OUT_MIN);
    else                  res = OUT_WIDTH'(v);
    return res;
  endfunction

endpackage

// File: rtl/dot_result_requant_lane.sv
// Two-stage requant arithmetic for one element: scale multiply, then
// rounding shift, zero-point offset and saturation with a clamp flag.
module dot_result_requant_lane
  import dot_result_requant_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_adv,
  input  logic                        i_valid,
  input  logic                        i_last,
  input  logic signed [IN_WIDTH-1:0]  i_data,
  input  requant_cfg_t                i_cfg,
  output logic                        o_s1_valid,
  output logic                        o_valid,
  output logic                        o_last,
  output logic                        o_sat,
  output logic signed [OUT_WIDTH-1:0] o_data
);

  logic                         r_s1_valid;
  logic                         r_s1_last;
  logic signed [PROD_WIDTH-1:0] r_prod;
  logic [SHIFT_WIDTH-1:0]       r_shift;
  logic signed [OUT_WIDTH-1:0]  r_zp;
  logic                         r_s2_valid;
  logic                         r_s2_last;
  logic                         r_s2_sat;
  logic signed [OUT_WIDTH-1:0]  r_s2_data;

  logic signed [PROD_WIDTH-1:0] w_prod;
  logic signed [PROD_WIDTH-1:0] w_half;
  logic signed [PROD_WIDTH-1:0] w_rounded;
  logic signed [SUM_WIDTH-1:0]  w_sum;

  // Zero-extended scale keeps the multiply signed and exact.
  assign w_prod = PROD_WIDTH'(i_data) * PROD_WIDTH'($signed({1'b0, i_cfg.scale}));

  always_comb begin
    w_half    = (r_shift == '0) ? '0 : (PROD_WIDTH'(1) << (r_shift - SHIFT_WIDTH'(1)));
    w_rounded = (r_prod + w_half) >>> r_shift;
    w_sum     = SUM_WIDTH'(w_rounded) + SUM_WIDTH'(r_zp);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_prod     <= '0;
      r_shift    <= '0;
      r_zp       <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_sat   <= 1'b0;
      r_s2_data  <= '0;
    end else if (i_adv) begin
      r_s1_valid <= i_valid;
      r_s1_last  <= i_valid && i_last;
      r_prod     <= w_prod;
      r_shift    <= i_cfg.shift;
      r_zp       <= $signed(i_cfg.zero_point);
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s2_sat   <= (w_sum > OUT_MAX) || (w_sum < OUT_MIN);
      r_s2_data  <= saturate(w_sum);
    end
  end

  assign o_s1_valid = r_s1_valid;
  assign o_valid    = r_s2_valid;
  assign o_last     = r_s2_last;
  assign o_sat      = r_s2_sat;
  assign o_data     = r_s2_data;

endmodule

// File: rtl/dot_result_requant.sv
// Requantizes INT32 dot-product results to INT8 and packs PACK elements per
// AXI-Stream beat; holds handshake, per-packet config latch and sat counter.
module dot_result_requant
  import dot_result_requant_pkg::*;
#(
  parameter int PACK      = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic signed [IN_WIDTH-1:0]  s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic                        s_axis_tlast,
  output logic [OUT_WIDTH*PACK-1:0]   m_axis_tdata,
  output logic [PACK-1:0]             m_axis_tkeep,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  input  logic [SCALE_WIDTH-1:0]      cfg_scale,
  input  logic [SHIFT_WIDTH-1:0]      cfg_shift,
  input  logic [OUT_WIDTH-1:0]        cfg_zero_point,
  input  logic                        clear_stats,
  output logic [CNT_WIDTH-1:0]        sat_count,
  output logic                        busy
);

  localparam int IDX_WIDTH = (PACK > 1) ? $clog2(PACK) : 1;

  logic                               r_rdy;
  logic                               r_first;
  requant_cfg_t                       r_cfg;
  logic [PACK-1:0][OUT_WIDTH-1:0]     r_data;
  logic [PACK-1:0]                    r_keep;
  logic                               r_tvalid;
  logic                               r_tlast;
  logic [IDX_WIDTH-1:0]               r_idx;
  logic [CNT_WIDTH-1:0]               r_sat_cnt;

  logic                               w_adv;
  logic                               w_accept;
  requant_cfg_t                       w_cfg_live;
  requant_cfg_t                       w_cfg;
  logic                               w_s1_valid;
  logic                               w_s2_valid;
  logic                               w_s2_last;
  logic                               w_s2_sat;
  logic signed [OUT_WIDTH-1:0]        w_s2_data;
  logic [PACK-1:0][OUT_WIDTH-1:0]     w_data_nxt;
  logic [PACK-1:0]                    w_keep_nxt;
  logic                               w_tvalid_nxt;
  logic                               w_tlast_nxt;
  logic [IDX_WIDTH-1:0]               w_idx_nxt;

  assign w_adv         = !r_tvalid || m_axis_tready;
  assign s_axis_tready = r_rdy && w_adv;
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  // The first beat of a packet uses the live config; later beats reuse the latch.
  assign w_cfg_live = '{scale: cfg_scale, shift: cfg_shift, zero_point: cfg_zero_point};
  assign w_cfg      = r_first ? w_cfg_live : r_cfg;

  dot_result_requant_lane u_lane (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_adv      (w_adv),
    .i_valid    (w_accept),
    .i_last     (s_axis_tlast),
    .i_data     (s_axis_tdata),
    .i_cfg      (w_cfg),
    .o_s1_valid (w_s1_valid),
    .o_valid    (w_s2_valid),
    .o_last     (w_s2_last),
    .o_sat      (w_s2_sat),
    .o_data     (w_s2_data)
  );

  // A beat being handed off this cycle is cleared so unused lanes read as zero.
  always_comb begin
    w_data_nxt   = r_tvalid ? '0 : r_data;
    w_keep_nxt   = r_tvalid ? '0 : r_keep;
    w_idx_nxt    = r_idx;
    w_tvalid_nxt = 1'b0;
    w_tlast_nxt  = 1'b0;
    if (w_s2_valid) begin
      w_data_nxt[r_idx] = w_s2_data;
      w_keep_nxt[r_idx] = 1'b1;
      if (w_s2_last || (r_idx == IDX_WIDTH'(PACK - 1))) begin
        w_tvalid_nxt = 1'b1;
        w_tlast_nxt  = w_s2_last;
        w_idx_nxt    = '0;
      end else begin
        w_idx_nxt = r_idx + IDX_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy    <= 1'b0;
      r_first  <= 1'b1;
      r_cfg    <= '0;
      r_data   <= '0;
      r_keep   <= '0;
      r_tvalid <= 1'b0;
      r_tlast  <= 1'b0;
      r_idx    <= '0;
    end else begin
      r_rdy <= 1'b1;
      if (w_accept) begin
        r_first <= s_axis_tlast;
        if (r_first) r_cfg <= w_cfg_live;
      end
      if (w_adv) begin
        r_data   <= w_data_nxt;
        r_keep   <= w_keep_nxt;
        r_tvalid <= w_tvalid_nxt;
        r_tlast  <= w_tlast_nxt;
        r_idx    <= w_idx_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_cnt <= '0;
    end else if (clear_stats) begin
      r_sat_cnt <= '0;
    end else if (w_adv && w_s2_valid && w_s2_sat && (r_sat_cnt != '1)) begin
      r_sat_cnt <= r_sat_cnt + CNT_WIDTH'(1);
    end
  end

  assign m_axis_tdata  = r_data;
  assign m_axis_tkeep  = r_keep;
  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign sat_count     = r_sat_cnt;
  assign busy          = w_s1_valid || w_s2_valid || (r_idx != '0) || r_tvalid;

endmodule

// File: tb/tb_dot_result_requant.sv
// Self-checking bench for dot_result_requant: arithmetic reference model with
// beat scoreboard, directed literal cases and randomized packets/backpressure.
module tb_dot_result_requant;

  localparam int PACK    = 4;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic signed [31:0]  s_axis_tdata;
  logic                s_axis_tvalid;
  logic                s_axis_tready;
  logic                s_axis_tlast;
  logic [8*PACK-1:0]   m_axis_tdata;
  logic [PACK-1:0]     m_axis_tkeep;
  logic                m_axis_tvalid;
  logic                m_axis_tready = 1'b1;
  logic                m_axis_tlast;
  logic [15:0]         cfg_scale;
  logic [4:0]          cfg_shift;
  logic [7:0]          cfg_zero_point;
  logic                clear_stats;
  logic [CNT_W-1:0]    sat_count;
  logic                busy;

  always #5 clk = ~clk;

  dot_result_requant #(.PACK(PACK), .CNT_WIDTH(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .cfg_scale      (cfg_scale),
    .cfg_shift      (cfg_shift),
    .cfg_zero_point (cfg_zero_point),
    .clear_stats    (clear_stats),
    .sat_count      (sat_count),
    .busy           (busy)
  );

  typedef struct {
    logic [8*PACK-1:0] data;
    logic [PACK-1:0]   keep;
    logic              last;
  } beat_t;

  beat_t             exp_q[$];
  beat_t             rx_q[$];
  logic [8*PACK-1:0] pend_data;
  logic [PACK-1:0]   pend_keep;
  int                pend_n;
  bit                m_first;
  int                m_scale, m_shift, m_zp;
  int                sat_model;
  int                n_cmp = 0;
  int                n_err = 0;
  bit                stall_force = 1'b0;
  int                rdy_pct = 100;
  bit                prev_stall = 1'b0;
  beat_t             prev_beat;
  int                stall_seen = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: exact product, round-half-up division by 2^shift, offset, clamp.
  function automatic int requant_ref(input int x, input int scale, input int shift,
                                     input int zp, output bit sat);
    longint p, d, num, q, v;
    p = longint'(x) * longint'(scale);
    if (shift == 0) begin
      q = p;
    end else begin
      d   = longint'(1) << shift;
      num = p + d / 2;
      q   = num / d;
      if ((num % d) != 0 && num < 0) q = q - 1;
    end
    v   = q + longint'(zp);
    sat = (v > 127) || (v < -128);
    if (v > 127) v = 127;
    else if (v < -128) v = -128;
    return int'(v);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    pend_data = '0;
    pend_keep = '0;
    pend_n    = 0;
    m_first   = 1'b1;
    sat_model = 0;
  endtask

  task automatic model_accept();
    bit sat;
    int e;
    if (m_first) begin
      m_scale = int'(cfg_scale);
      m_shift = int'(cfg_shift);
      m_zp    = int'($signed(cfg_zero_point));
    end
    m_first = s_axis_tlast;
    e = requant_ref(int'(s_axis_tdata), m_scale, m_shift, m_zp, sat);
    if (sat && sat_model < CNT_MAX) sat_model++;
    pend_data[pend_n*8 +: 8] = e[7:0];
    pend_keep[pend_n] = 1'b1;
    pend_n++;
    if (pend_n == PACK || s_axis_tlast) begin
      exp_q.push_back('{pend_data, pend_keep, s_axis_tlast});
      pend_data = '0;
      pend_keep = '0;
      pend_n    = 0;
    end
  endtask

  // Output sink readiness, changed just after each rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = stall_force ? 1'b0 : (int'($urandom_range(0, 99)) < rdy_pct);
    end
  end

  // Compare process: inputs are stable at the falling edge, so a handshake seen
  // here completes on the following rising edge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_tvalid", m_axis_tvalid, 1);
          chk("stall_tdata", m_axis_tdata, prev_beat.data);
          chk("stall_tkeep", m_axis_tkeep, prev_beat.keep);
          chk("stall_tlast", m_axis_tlast, prev_beat.last);
        end
        if (m_axis_tvalid && !m_axis_tready) begin
          chk("stall_s_tready", s_axis_tready, 0);
          stall_seen++;
          prev_stall = 1'b1;
          prev_beat  = '{m_axis_tdata, m_axis_tkeep, m_axis_tlast};
        end else begin
          prev_stall = 1'b0;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          rx_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast});
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL beat_unexpected: got tdata %0h tkeep %0h with no beat expected",
                     m_axis_tdata, m_axis_tkeep);
          end else begin
            e = exp_q.pop_front();
            chk("beat_tdata", m_axis_tdata, e.data);
            chk("beat_tkeep", m_axis_tkeep, e.keep);
            chk("beat_tlast", m_axis_tlast, e.last);
          end
        end
        if (s_axis_tvalid && s_axis_tready) model_accept();
      end
    end
  end

  task automatic set_cfg(input logic [15:0] sc, input logic [4:0] sh, input logic [7:0] zp);
    cfg_scale      = sc;
    cfg_shift      = sh;
    cfg_zero_point = zp;
  endtask

  task automatic send(input int x, input bit last);
    int t = 0;
    s_axis_tdata  = x;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    while (!s_axis_tready && t < 1000) begin
      t++;
      @(negedge clk);
    end
    if (!s_axis_tready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: s_axis_tready got 0 expected 1 after %0d cycles", t);
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((busy || m_axis_tvalid) && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain_idle", {busy, m_axis_tvalid}, 2'b00);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({tag, "_m_tdata"}, m_axis_tdata, 0);
    chk({tag, "_m_tkeep"}, m_axis_tkeep, 0);
    chk({tag, "_m_tlast"}, m_axis_tlast, 0);
    chk({tag, "_sat_count"}, sat_count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_s_tready"}, s_axis_tready, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int n, s0, nb;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tlast  = 1'b0;
    clear_stats   = 1'b0;
    set_cfg(16'd1, 5'd0, 8'd0);
    model_reset();
    #1 rst_n = 1'b0;
    #2;
    check_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("tready_before_edge", s_axis_tready, 0);
    @(posedge clk);
    #1;
    chk("tready_after_edge", s_axis_tready, 1);

    // Identity requant, one full beat.
    set_cfg(16'd1, 5'd0, 8'd0);
    send(100, 0); send(-50, 0); send(7, 0); send(0, 1);
    drain();
    chk("t1_tdata", rx_q[$].data, 32'h0007CE64);
    chk("t1_tkeep", rx_q[$].keep, 4'b1111);
    chk("t1_tlast", rx_q[$].last, 1);
    chk("t1_sat", sat_count, 0);

    // Rounding shift, short packet.
    set_cfg(16'd3, 5'd2, 8'd0);
    send(10, 0); send(-10, 0); send(2, 1);
    drain();
    chk("t2_tdata", rx_q[$].data, 32'h0002F908);
    chk("t2_tkeep", rx_q[$].keep, 4'b0111);
    chk("t2_tlast", rx_q[$].last, 1);

    // Config change mid-packet is ignored.
    set_cfg(16'd2, 5'd0, 8'd0);
    send(5, 0);
    set_cfg(16'd100, 5'd0, 8'd0);
    send(6, 1);
    drain();
    chk("t2b_tdata", rx_q[$].data, 32'h00000C0A);
    chk("t2b_tkeep", rx_q[$].keep, 4'b0011);

    // Zero point and saturation.
    set_cfg(16'd1, 5'd0, 8'd5);
    send(200, 0); send(-300, 0); send(122, 0); send(123, 1);
    drain();
    chk("t3_tdata", rx_q[$].data, 32'h7F7F807F);
    chk("t3_sat", sat_count, 3);
    clear_stats = 1'b1;
    @(posedge clk);
    #1;
    clear_stats = 1'b0;
    sat_model   = 0;
    chk("t3_sat_cleared", sat_count, 0);

    // Six elements: one full beat, one partial.
    set_cfg(16'd1, 5'd0, 8'd0);
    for (int i = 1; i <= 6; i++) send(i, i == 6);
    drain();
    n = rx_q.size();
    chk("t4_b1_tdata", rx_q[n-2].data, 32'h04030201);
    chk("t4_b1_tkeep", rx_q[n-2].keep, 4'b1111);
    chk("t4_b1_tlast", rx_q[n-2].last, 0);
    chk("t4_b2_tdata", rx_q[n-1].data, 32'h00000605);
    chk("t4_b2_tkeep", rx_q[n-1].keep, 4'b0011);
    chk("t4_b2_tlast", rx_q[n-1].last, 1);

    // Five-cycle sink stall in the middle of a continuous stream.
    s0 = stall_seen;
    nb = rx_q.size();
    fork
      begin
        for (int i = 0; i < 12; i++) send(i * 3 - 10, i == 11);
      end
      begin
        repeat (6) @(negedge clk);
        stall_force = 1'b1;
        repeat (5) @(negedge clk);
        stall_force = 1'b0;
      end
    join
    drain();
    chk("t5_stall_observed", stall_seen > s0, 1);
    chk("t5_beats", rx_q.size() - nb, 3);

    // Reset in the middle of a packet.
    set_cfg(16'd1, 5'd0, 8'd0);
    send(11, 0); send(22, 0);
    chk("t6_busy_midpkt", busy, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("t6_rst");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    nb = rx_q.size();
    send(9, 0); send(8, 0); send(7, 0); send(6, 1);
    drain();
    chk("t6_beats", rx_q.size() - nb, 1);
    chk("t6_tdata", rx_q[$].data, 32'h06070809);
    chk("t6_tkeep", rx_q[$].keep, 4'b1111);

    // Randomized packets, configs, gaps and backpressure.
    rdy_pct = 70;
    for (int p = 0; p < 40; p++) begin
      int len;
      len = int'($urandom_range(1, 9));
      set_cfg(($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(1, 300)),
              5'($urandom_range(0, 31)), 8'($urandom));
      for (int i = 0; i < len; i++) begin
        int x;
        x = ($urandom_range(0, 1) == 1) ? int'($urandom) : int'($urandom_range(0, 600)) - 300;
        if (i > 0 && $urandom_range(0, 3) == 0)
          set_cfg(16'($urandom), 5'($urandom_range(0, 31)), 8'($urandom));
        send(x, i == len - 1);
        if ($urandom_range(0, 2) == 0) begin
          repeat (int'($urandom_range(1, 3))) begin
            @(posedge clk);
            #1;
          end
        end
      end
    end
    drain();
    chk("rand_sat_count", sat_count, sat_model);
    chk("rand_exp_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dot_result_requant.md
Name: dot_result_requant

Overview:
- Downstream stage of the vector dot-product engine. Consumes its stream of signed INT32 dot-product results.
- Requantizes each result to signed INT8: multiply by scale, rounding right shift, add zero point, saturate.
- Packs PACK results per output beat for the next layer's activation stream.
- Fully pipelined, one result per cycle, with AXI-Stream backpressure and a saturation event counter.

Parameters:
- IN_WIDTH, 32, signed input result width
- SCALE_WIDTH, 16, unsigned scale multiplier width
- OUT_WIDTH, 8, signed output element width
- PACK, 4, output elements per beat (1..16)
- CNT_WIDTH, 16, saturation counter width

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  IN_WIDTH  signed dot-product result
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- s_axis_tlast  in  1  last result of packet
- m_axis_tdata  out  OUT_WIDTH*PACK  packed INT8 results, element 0 at LSBs
- m_axis_tkeep  out  PACK  per-lane valid mask
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tlast  out  1  beat holds last element of packet
- cfg_scale  in  SCALE_WIDTH  unsigned multiplier
- cfg_shift  in  5  right shift, 0..31
- cfg_zero_point  in  OUT_WIDTH  signed zero point added after shift
- clear_stats  in  1  synchronous clear of sat_count
- sat_count  out  CNT_WIDTH  saturated-element count; sticks at max
- busy  out  1  any stage or packer holds data

Behaviour:
- Reset (asynchronous, rst_n low): all pipeline valids 0, packer lane index 0.
- Reset values of outputs: m_axis_tvalid=0, m_axis_tdata=0, m_axis_tkeep=0, m_axis_tlast=0, sat_count=0, busy=0, s_axis_tready=0.
- s_axis_tready is 1 from the first clock edge after reset release.
- Reset mid-packet discards all in-flight data. No partial beat is emitted.
- Advance condition: adv = !m_axis_tvalid || m_axis_tready.
  - All stages move only when adv is high. s_axis_tready = adv (combinational).
  - Input accepted on s_axis_tvalid && s_axis_tready.
- Configuration:
  - cfg_* are latched on the first accepted beat of each packet (after reset, or after a beat with tlast).
  - Latched values apply to the whole packet. Mid-packet cfg changes are ignored.
- S1 (register): prod = signed(in) * signed({1'b0,cfg_scale}). Width IN_WIDTH+SCALE_WIDTH+1, exact.
- S2 (register):
  - Rounding: r = (prod + (1<<(shift-1))) >>> shift when shift>0; r = prod when shift=0. This is round half toward +inf, arithmetic shift.
  - Offset: v = r + zero_point, sign-extended, no overflow.
  - Saturate v to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Set the sat flag if clamped.
- S3 (packer):
  - Writes the element into lane idx and sets tkeep[idx]. idx increments.
  - The beat is emitted (m_axis_tvalid=1) when idx reaches PACK-1, or when the element carries tlast.
  - After emission, idx returns to 0. Unused lanes are 0. m_axis_tlast = tlast of the final element.
- Latency: accepted input to its element in the packer register is 3 adv cycles.
  - PACK=1: m_axis_tvalid rises 3 cycles after acceptance with no stall.
- Throughput: one element per cycle while m_axis_tready=1.
- Backpressure: while m_axis_tvalid && !m_axis_tready, all of the following hold:
  - m_axis_* is held stable;
  - the pipeline freezes and s_axis_tready=0;
  - no data is lost or duplicated.
- Bubbles (input not valid) propagate as invalid stages and do not advance idx.
- sat_count increments by 1 per saturated element when it leaves S2 under adv, and sticks at 2^CNT_WIDTH-1.
- clear_stats zeroes sat_count. If clear_stats and an increment occur in the same cycle, the result is 0.
- busy = OR of the S1/S2 valids, idx!=0, and m_axis_tvalid.

Decomposition:
- Shared package holds:
  - localparams PROD_WIDTH=IN_WIDTH+SCALE_WIDTH+1, OUT_MAX and OUT_MIN;
  - typedef of the requant configuration struct {scale, shift, zero_point};
  - a saturate function.
- One natural sub-module: requant_lane, covering S1–S2 arithmetic for one element plus the sat flag. The top level holds the packer, handshake, config latch and counter.

Test Plan:
- scale=1, shift=0, zp=0; inputs 100, -50, 7, 0 with tlast on the last, PACK=4 -> one beat tdata lanes {0,7,-50,100}, tkeep=4'b1111, tlast=1, sat_count=0.
- scale=3, shift=2, zp=0; inputs 10, -10, 2 -> outputs 8, -7, 2. With -10: -30+2=-28, >>>2 = -7. With 2: 6+2 = 8, >>>2 = 2.
- scale=1, shift=0, zp=5; inputs 200, -300, 122, 123 -> 127, -128, 127, 127; sat_count=3. Then pulse clear_stats -> sat_count=0.
- PACK=4; 6 inputs 1..6 with tlast on 6 -> beat1 {4,3,2,1} keep 1111 tlast=0; beat2 {0,0,6,5} keep 0011 tlast=1.
- Continuous input stream; m_axis_tready held low 5 cycles mid-stream -> tdata/tkeep stable during the stall, s_axis_tready=0, all elements delivered once and in order.
- Assert rst_n low for 1 cycle after 2 of 4 elements accepted -> outputs return to reset values immediately. A following fresh 4-element packet emits exactly one correct beat.
